// File: rtl/sysbus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sysbus_arbiter_if
//  Description : Handshake bundle between the two Sysbus requesters (fetch,
//                data), the arbiter and the top-level bus pins.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sysbus_arbiter_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    // Requester 0: instruction fetch
    logic                      rq0_valid;
    logic [BUS_DATA_WIDTH-1:0] rq0_addr;
    logic [BUS_TAG_WIDTH-1:0]  rq0_tag;
    logic                      rq0_ready;
    logic                      rq0_resp_valid;
    logic                      rq0_resp_ready;
    logic                      rq0_resp_last;

    // Requester 1: data memory
    logic                      rq1_valid;
    logic [BUS_DATA_WIDTH-1:0] rq1_addr;
    logic [BUS_TAG_WIDTH-1:0]  rq1_tag;
    logic                      rq1_ready;
    logic                      rq1_resp_valid;
    logic                      rq1_resp_ready;
    logic                      rq1_resp_last;

    // Shared beat payload delivered to whichever requester owns the burst
    logic [BUS_DATA_WIDTH-1:0] resp_data;

    // Sysbus pins
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    // Arbiter side
    modport master (
        input  rq0_valid, rq0_addr, rq0_tag, rq0_resp_ready,
        input  rq1_valid, rq1_addr, rq1_tag, rq1_resp_ready,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output rq0_ready, rq0_resp_valid, rq0_resp_last,
        output rq1_ready, rq1_resp_valid, rq1_resp_last,
        output resp_data, bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    // Requester / bus side
    modport slave (
        output rq0_valid, rq0_addr, rq0_tag, rq0_resp_ready,
        output rq1_valid, rq1_addr, rq1_tag, rq1_resp_ready,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  rq0_ready, rq0_resp_valid, rq0_resp_last,
        input  rq1_ready, rq1_resp_valid, rq1_resp_last,
        input  resp_data, bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface
`default_nettype wire

// File: rtl/sysbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sysbus_arbiter
//  Description : Shares the single Sysbus read port between instruction fetch
//                (requester 0) and data memory (requester 1). One whole
//                transaction at a time: request/ack, BEATS response beats,
//                release. Round-robin when both requesters contend.
//  Revision    : 1.0 - initial release
// ============================================================================
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input wire               clk,
    input wire               reset,
    sysbus_arbiter_if.master bus_if
);

    localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]                state;
    logic [CNT_W-1:0]          count;
    logic                      owner;
    logic                      last_grant;
    logic                      grant;
    logic                      req_cyc;
    logic [BUS_DATA_WIDTH-1:0] req_addr;
    logic [BUS_TAG_WIDTH-1:0]  req_tag;
    logic                      ready0;
    logic                      ready1;

    logic                      in_resp;
    logic                      owner_resp_ready;
    logic                      beat_valid;
    logic                      beat_ack;
    logic                      beat_last;

    // Response tags are not checked; only one transaction is ever outstanding.
    logic unused_resptag;
    assign unused_resptag = ^bus_if.bus_resptag;

    // Grant selection: a lone requester wins, contention goes to whoever was not served last
    always_comb begin
        grant = bus_if.rq1_valid;
        if (bus_if.rq0_valid && bus_if.rq1_valid) begin
            grant = ~last_grant;
        end
    end

    // Transaction sequencer: IDLE -> REQ -> RESP -> IDLE, with beat counting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            req_cyc    <= 1'b0;
            req_addr   <= '0;
            req_tag    <= '0;
            ready0     <= 1'b0;
            ready1     <= 1'b0;
        end else begin
            ready0 <= 1'b0;
            ready1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus_if.rq0_valid || bus_if.rq1_valid) begin
                        owner    <= grant;
                        req_cyc  <= 1'b1;
                        req_addr <= grant ? bus_if.rq1_addr : bus_if.rq0_addr;
                        req_tag  <= grant ? bus_if.rq1_tag  : bus_if.rq0_tag;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // Address and tag stay frozen until the bus takes them
                    if (bus_if.bus_reqack) begin
                        ready0  <= ~owner;
                        ready1  <= owner;
                        req_cyc <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (beat_ack) begin
                        if (count == LAST_BEAT) begin
                            count      <= '0;
                            last_grant <= owner;
                            state      <= IDLE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Beat path is combinational so backpressure reaches the bus in the same cycle
    assign in_resp          = (state == RESP);
    assign owner_resp_ready = owner ? bus_if.rq1_resp_ready : bus_if.rq0_resp_ready;
    assign beat_valid       = in_resp & bus_if.bus_respcyc;
    assign beat_ack         = beat_valid & owner_resp_ready;
    assign beat_last        = beat_valid & (count == LAST_BEAT);

    assign bus_if.bus_respack    = beat_ack;
    assign bus_if.rq0_resp_valid = beat_valid & ~owner;
    assign bus_if.rq1_resp_valid = beat_valid & owner;
    assign bus_if.rq0_resp_last  = beat_last & ~owner;
    assign bus_if.rq1_resp_last  = beat_last & owner;
    assign bus_if.resp_data      = in_resp ? bus_if.bus_resp : '0;

    assign bus_if.bus_reqcyc = req_cyc;
    assign bus_if.bus_req    = req_addr;
    assign bus_if.bus_reqtag = req_tag;
    assign bus_if.rq0_ready  = ready0;
    assign bus_if.rq1_ready  = ready1;

endmodule
`default_nettype wire

// File: tb/tb_sysbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sysbus_arbiter
//  Description : Self-checking bench for sysbus_arbiter. A table of
//                transaction scenarios drives the requesters and a small bus
//                model; expected requests and beats are queued as stimulus
//                is driven and compared when the DUT hands them over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sysbus_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;
    localparam int NVEC  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bif ();

    sysbus_arbiter #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH (TW),
        .BEATS         (BEATS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus_if(bif.master)
    );

    typedef struct {
        bit          v0;
        bit          v1;
        bit          first;
        logic [63:0] a0;
        logic [63:0] a1;
        logic [TW-1:0] t0;
        logic [TW-1:0] t1;
        int          ack_dly;
        int          stall_beat;
        int          stall_len;
        bit          spur;
        int          abort;
    } vec_t;

    typedef struct packed {
        logic        own;
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [63:0]   addr;
        logic [TW-1:0] tag;
    } req_t;

    vec_t  vecs[NVEC];
    beat_t beat_q[$];
    req_t  req_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] bdata(input int idx, input logic own, input int b);
        return (64'(idx) << 56) | (64'(own) << 48) | (64'h11 * 64'(b + 1));
    endfunction

    task automatic set_ready(input logic own, input logic rdy);
        if (own) bif.rq1_resp_ready = rdy;
        else     bif.rq0_resp_ready = rdy;
    endtask

    task automatic drive_beat(input int idx, input logic own, input int b);
        bif.bus_resp    = bdata(idx, own, b);
        bif.bus_resptag = TW'(b);
        beat_q.push_back('{own: own, data: bdata(idx, own, b), last: (b == BEATS - 1)});
    endtask

    task automatic spurious_chk();
        chk("spur_respack", bif.bus_respack, 0);
        chk("spur_resp_valid", bif.rq0_resp_valid | bif.rq1_resp_valid, 0);
    endtask

    // Monitor: request handoff and accepted beats against the scoreboard queues
    always @(negedge clk) begin
        req_t  r;
        beat_t b;
        if (reset) begin
            if (bif.bus_reqcyc && bif.bus_reqack) begin
                chk("req_expected", req_q.size() != 0, 1);
                if (req_q.size() != 0) begin
                    r = req_q.pop_front();
                    chk("req_addr_at_ack", bif.bus_req, r.addr);
                    chk("req_tag_at_ack", bif.bus_reqtag, r.tag);
                end
            end
            if (bif.rq0_resp_valid && bif.rq1_resp_valid) begin
                chk("both_resp_valid", 1, 0);
            end
            if (bif.bus_respack) begin
                chk("beat_expected", beat_q.size() != 0, 1);
                if (beat_q.size() != 0) begin
                    b = beat_q.pop_front();
                    chk("beat_owner_valid", b.own ? bif.rq1_resp_valid : bif.rq0_resp_valid, 1);
                    chk("beat_other_valid", b.own ? bif.rq0_resp_valid : bif.rq1_resp_valid, 0);
                    chk("beat_data", bif.resp_data, b.data);
                    chk("beat_last", b.own ? bif.rq1_resp_last : bif.rq0_resp_last, b.last);
                end
            end else if ((bif.rq0_resp_valid || bif.rq1_resp_valid) && beat_q.size() != 0) begin
                b = beat_q[0];
                chk("pending_data", bif.resp_data, b.data);
                chk("pending_last", b.own ? bif.rq1_resp_last : bif.rq0_resp_last, b.last);
            end
        end
    end

    task automatic do_abort();
        bif.bus_resp = 64'hFFFF_0000_FFFF_0000;
        #1 reset = 1'b0;
        #1;
        chk("abort_reqcyc", bif.bus_reqcyc, 0);
        chk("abort_req", bif.bus_req, 0);
        chk("abort_reqtag", bif.bus_reqtag, 0);
        chk("abort_ready", {bif.rq0_ready, bif.rq1_ready}, 0);
        chk("abort_respack", bif.bus_respack, 0);
        chk("abort_resp_valid", {bif.rq0_resp_valid, bif.rq1_resp_valid}, 0);
        chk("abort_resp_last", {bif.rq0_resp_last, bif.rq1_resp_last}, 0);
        chk("abort_resp_data", bif.resp_data, 0);
        bif.bus_respcyc    = 1'b0;
        bif.rq0_valid      = 1'b0;
        bif.rq1_valid      = 1'b0;
        bif.rq0_resp_ready = 1'b1;
        bif.rq1_resp_ready = 1'b1;
        beat_q.delete();
        req_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int            n, cyc, acked, beat, stall_left;
        logic          own, rdy, consumed, done;
        logic [63:0]   ea;
        logic [TW-1:0] et;
        n = (v.v0 && v.v1) ? 2 : 1;
        @(posedge clk); #1;
        bif.rq0_valid = v.v0; bif.rq0_addr = v.a0; bif.rq0_tag = v.t0;
        bif.rq1_valid = v.v1; bif.rq1_addr = v.a1; bif.rq1_tag = v.t1;
        if (v.spur) begin
            bif.bus_respcyc = 1'b1;
            bif.bus_resp    = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        for (int t = 0; t < n; t++) begin
            own = (t == 0) ? v.first : ~v.first;
            ea  = own ? v.a1 : v.a0;
            et  = own ? v.t1 : v.t0;
            req_q.push_back('{addr: ea, tag: et});
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (v.spur) spurious_chk();
            end while (!bif.bus_reqcyc && cyc < 40);
            chk("reqcyc_seen", bif.bus_reqcyc, 1);
            if (!bif.bus_reqcyc) return;
            if (t == 0) chk("grant_latency", cyc, 2);
            chk("req_addr", bif.bus_req, ea);
            chk("req_tag", bif.bus_reqtag, et);
            for (int w = 0; w < v.ack_dly; w++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("hold_reqcyc", bif.bus_reqcyc, 1);
                chk("hold_req", bif.bus_req, ea);
                chk("hold_reqtag", bif.bus_reqtag, et);
                chk("ready_before_ack", {bif.rq0_ready, bif.rq1_ready}, 0);
                if (v.spur) spurious_chk();
            end
            @(posedge clk); #1;
            bif.bus_reqack = 1'b1;
            @(negedge clk);
            chk("ready_at_ack", {bif.rq0_ready, bif.rq1_ready}, 0);
            if (v.spur) spurious_chk();
            @(posedge clk); #1;
            bif.bus_reqack  = 1'b0;
            bif.bus_respcyc = 1'b1;
            beat       = 0;
            acked      = 0;
            stall_left = v.stall_len;
            drive_beat(idx, own, beat);
            rdy = !((beat == v.stall_beat) && (stall_left > 0));
            set_ready(own, rdy);
            @(negedge clk);
            chk("ready_pulse_owner", own ? bif.rq1_ready : bif.rq0_ready, 1);
            chk("ready_pulse_other", own ? bif.rq0_ready : bif.rq1_ready, 0);
            chk("reqcyc_dropped", bif.bus_reqcyc, 0);
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 100) begin
                cyc++;
                if (!rdy) begin
                    chk("stall_respack", bif.bus_respack, 0);
                    stall_left--;
                end
                consumed = bif.bus_respack;
                if (consumed) acked++;
                @(posedge clk); #1;
                if (cyc == 1) begin
                    if (own) bif.rq1_valid = 1'b0;
                    else     bif.rq0_valid = 1'b0;
                end
                if (consumed && v.abort != 0 && acked == v.abort) begin
                    do_abort();
                    return;
                end
                if (consumed) begin
                    beat++;
                    if (beat == BEATS) begin
                        bif.bus_respcyc = 1'b0;
                        set_ready(own, 1'b1);
                        done = 1'b1;
                    end else begin
                        drive_beat(idx, own, beat);
                    end
                end
                if (!done) begin
                    rdy = !((beat == v.stall_beat) && (stall_left > 0));
                    set_ready(own, rdy);
                    @(negedge clk);
                    if (cyc == 1) chk("ready_single_pulse", {bif.rq0_ready, bif.rq1_ready}, 0);
                end
            end
            chk("beats_acked", acked, BEATS);
        end
    endtask

    initial begin
        reset              = 1'b1;
        bif.rq0_valid      = 1'b0; bif.rq0_addr = '0; bif.rq0_tag = '0;
        bif.rq1_valid      = 1'b0; bif.rq1_addr = '0; bif.rq1_tag = '0;
        bif.rq0_resp_ready = 1'b1;
        bif.rq1_resp_ready = 1'b1;
        bif.bus_reqack     = 1'b0;
        bif.bus_respcyc    = 1'b0;
        bif.bus_resp       = '0;
        bif.bus_resptag    = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_reqcyc", bif.bus_reqcyc, 0);
        chk("rst_req", bif.bus_req, 0);
        chk("rst_reqtag", bif.bus_reqtag, 0);
        chk("rst_ready", {bif.rq0_ready, bif.rq1_ready}, 0);
        chk("rst_respack", bif.bus_respack, 0);
        chk("rst_resp_valid", {bif.rq0_resp_valid, bif.rq1_resp_valid}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        //         v0    v1    first a0          a1          t0      t1      ack sb  sl spur  abort
        vecs[0] = '{1'b1, 1'b1, 1'b0, 64'h1000, 64'h2000, 13'h001, 13'h101, 2, -1, 0, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 64'h1040, 64'h2040, 13'h002, 13'h102, 0, -1, 0, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 64'h0,    64'h2080, 13'h000, 13'h103, 1,  4, 3, 1'b0, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 64'h10c0, 64'h0,    13'h004, 13'h000, 2, -1, 0, 1'b1, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 64'h1100, 64'h0,    13'h005, 13'h000, 1, -1, 0, 1'b0, 3};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 64'h1000, 64'h0,    13'h006, 13'h000, 2, -1, 0, 1'b0, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 64'h1140, 64'h0,    13'h007, 13'h000, 10, -1, 0, 1'b0, 0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 64'h1180, 64'h2180, 13'h008, 13'h108, 0, -1, 0, 1'b0, 0};

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        repeat (3) @(negedge clk);
        chk("req_q_drained", req_q.size(), 0);
        chk("beat_q_drained", beat_q.size(), 0);
        chk("final_idle_reqcyc", bif.bus_reqcyc, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no completion, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
